uncached_lsu_queue: RTL and testbench
=====================================

UNCACHED_LSU_QUEUE -- requirements
Module: uncached_lsu_queue

Interface
REQ-001 The module SHALL have parameter LANES, default 2, meaning the number of issue lanes that may present memory requests.
REQ-002 The module SHALL have parameter DEPTH, default 4 (power of two, at least 2), meaning the number of request-queue entries.
REQ-003 The module SHALL have parameter ADDR_W, default 32, meaning the physical address width.
REQ-004 The module SHALL have the following ports, one per entry, listed as name, direction, width, meaning:
 - clk  in  1  the single clock; all logic on its rising edge.
 - rst  in  1  reset, synchronous and active-high.
 - req_valid_i  in  LANES  per-lane request valid.
 - req_ready_o  out  LANES  per-lane accept.
 - req_write_i  in  LANES  1 means store, 0 means load.
 - req_type_i  in  LANES x 2  access size: 0 byte, 1 half, 2 word.
 - req_signed_i  in  LANES  sign-extend the load result.
 - req_addr_i  in  LANES x ADDR_W  physical address.
 - req_wdata_i  in  LANES x 32  store data, right-aligned.
 - err_o  out  1  misaligned-request pulse.
 - bus_valid_o  out  1  bus address phase valid.
 - bus_ready_i  in  1  bus accepts the address phase.
 - bus_write_o  out  1  bus direction.
 - bus_addr_o  out  ADDR_W  bus address.
 - bus_size_o  out  2  bus access size.
 - bus_strb_o  out  4  byte strobe.
 - bus_wdata_o  out  32  lane-shifted store data.
 - bus_data_ok_i  in  1  data phase complete (read data valid or write acknowledged).
 - bus_rdata_i  in  32  bus read data.
 - rsp_valid_o  out  1  load result valid.
 - rsp_lane_o  out  $clog2(LANES)  lane that originated the load.
 - rsp_data_o  out  32  extended load data.
 - busy_o  out  1  the unit holds outstanding work.

Function
REQ-005 Arbitration: the lowest-index lane with req_valid_i SHALL be selected; only that lane's req_ready_o SHALL be driven high, and only when the queue is not full.
REQ-006 Handshake: a request SHALL be accepted in a cycle where valid and ready are both high; ready SHALL depend only on the registered count (no enqueue at full, even if a dequeue occurs in the same cycle).
REQ-007 Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be accepted but not enqueued, and err_o SHALL pulse for exactly one cycle in the following cycle.
REQ-008 Queue: the queue SHALL be an in-order FIFO of {write, type, signed, addr, wdata, lane}; read and write pointers SHALL wrap modulo DEPTH; simultaneous enqueue and dequeue SHALL leave the count unchanged.
REQ-009 The FSM SHALL have states IDLE, ADDR and DATA (one-hot), with these transitions:
 - IDLE to ADDR when count is greater than 0.
 - ADDR to DATA on bus_ready_i.
 - DATA to IDLE on bus_data_ok_i; the head entry SHALL be popped in that cycle.
REQ-010 Bus outputs:
 - bus_valid_o SHALL equal (state==ADDR).
 - bus_addr_o, bus_write_o and bus_size_o SHALL come from the head entry and be held stable across ADDR and DATA.
REQ-011 Store alignment:
 - bus_wdata_o SHALL be wdata shifted left by 8*addr[1:0].
 - bus_strb_o SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<(2*addr[1]) for half, and 4'b1111 for word.
 - For loads, bus_strb_o SHALL be 0.
REQ-012 Load extraction: the load result SHALL be bus_rdata_i shifted right by 8*addr[1:0], truncated to the access size, then sign- or zero-extended per the signed field.
REQ-013 Load response: rsp_valid_o SHALL be registered and asserted for exactly one cycle, in the cycle after the load's bus_data_ok_i; rsp_lane_o and rsp_data_o are valid only while rsp_valid_o is high.
REQ-014 Stores SHALL be posted, producing no response.
REQ-015 Load latency: minimum latency from acceptance (cycle 0) to rsp_valid_o SHALL be 4 cycles (entry visible in 1, ADDR in 2, DATA in 3, response in 4), given bus_ready_i and bus_data_ok_i are asserted immediately.
REQ-016 Throughput: back-to-back entries SHALL spend exactly one cycle in IDLE between transactions.
REQ-017 busy_o SHALL be combinational and equal (count!=0) | (state!=IDLE) | rsp_valid_o.
REQ-018 bus_data_ok_i SHALL be ignored outside DATA, and bus_ready_i SHALL be ignored outside ADDR.

Reset
REQ-019 While rst is high at a clock edge, the following SHALL clear: pointers, count, FSM (to IDLE), rsp_valid_o, err_o.
REQ-020 From the cycle after reset, the following outputs SHALL be 0: bus_valid_o, req_ready_o, rsp_valid_o, err_o, busy_o.
REQ-021 Reset asserted mid-transaction SHALL abandon the in-flight bus access and all queued entries without issuing a response.

Verification
REQ-022 A bench SHALL cover: lane0 signed byte load at address 0x1003 with bus_rdata_i=0x80FF_FF_FF, and ready and data_ok immediate, producing bus_strb_o=0 and rsp_valid_o in cycle 4 with rsp_data_o=0xFFFFFF80 and rsp_lane_o=0.
REQ-023 A bench SHALL cover: lanes 0 and 1 both valid with stores, where req_ready_o=01 so lane0 wins; a lane1 half store of 0xABCD to 0x2002 producing bus_strb_o=1100 and bus_wdata_o=0xABCD0000.
REQ-024 A bench SHALL cover: a word load to 0x3002 producing an err_o pulse one cycle later, no bus_valid_o, and count remaining 0.
REQ-025 A bench SHALL cover: bus_ready_i held low while DEPTH+1 requests are issued, showing req_ready_o=0 after the DEPTH-th acceptance, then in-order drain and three responses with correct lanes.
REQ-026 A bench SHALL cover: rst asserted during DATA with 2 entries queued, after which every output is 0 the next cycle and busy_o is 0.

Source files
------------

// File: rtl/uncached_lsu_queue.sv
// Uncached load/store queue: arbitrates issue lanes into an in-order FIFO and
// plays each entry out as a single address/data bus transaction.
module uncached_lsu_queue #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              req_valid_i,
    output logic [LANES-1:0]              req_ready_o,
    input  logic [LANES-1:0]              req_write_i,
    input  logic [LANES-1:0][1:0]         req_type_i,
    input  logic [LANES-1:0]              req_signed_i,
    input  logic [LANES-1:0][ADDR_W-1:0]  req_addr_i,
    input  logic [LANES-1:0][31:0]        req_wdata_i,
    output logic                          err_o,
    output logic                          bus_valid_o,
    input  logic                          bus_ready_i,
    output logic                          bus_write_o,
    output logic [ADDR_W-1:0]             bus_addr_o,
    output logic [1:0]                    bus_size_o,
    output logic [3:0]                    bus_strb_o,
    output logic [31:0]                   bus_wdata_o,
    input  logic                          bus_data_ok_i,
    input  logic [31:0]                   bus_rdata_i,
    output logic                          rsp_valid_o,
    output logic [$clog2(LANES)-1:0]      rsp_lane_o,
    output logic [31:0]                   rsp_data_o,
    output logic                          busy_o
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {IDLE = 3'b001, ADDR = 3'b010, DATA = 3'b100} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = (size == 2'd1 && off[0]) || (size >= 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    strobe = 4'b0001 << off;
            2'd1:    strobe = 4'b0011 << {off[1], 1'b0};
            default: strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'd0:    load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    state_t              state, state_nx;
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    count;
    logic [LANE_W-1:0]   sel;
    logic                any_valid, full, accept, misaligned, push, pop, active;

    logic                mem_write  [DEPTH];
    logic [1:0]          mem_type   [DEPTH];
    logic                mem_signed [DEPTH];
    logic [ADDR_W-1:0]   mem_addr   [DEPTH];
    logic [31:0]         mem_wdata  [DEPTH];
    logic [LANE_W-1:0]   mem_lane   [DEPTH];

    logic [LANE_W-1:0]   rsp_lane_p1;
    logic [31:0]         rsp_data_p1;

    // Lowest-index valid lane wins; ready only looks at the registered count.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                sel       = LANE_W'(i);
                any_valid = 1'b1;
            end
        end
    end

    assign full        = (count == CNT_W'(DEPTH));
    assign accept      = any_valid && !full;
    assign req_ready_o = accept ? (LANES'(1) << sel) : '0;
    assign misaligned  = is_misaligned(req_type_i[sel], req_addr_i[sel][1:0]);
    assign push        = accept && !misaligned;
    assign pop         = (state == DATA) && bus_data_ok_i;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_write[wptr]  <= req_write_i[sel];
            mem_type[wptr]   <= req_type_i[sel];
            mem_signed[wptr] <= req_signed_i[sel];
            mem_addr[wptr]   <= req_addr_i[sel];
            mem_wdata[wptr]  <= req_wdata_i[sel];
            mem_lane[wptr]   <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            err_o       <= 1'b0;
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_o       <= accept && misaligned;
            rsp_valid_o <= pop && !mem_write[rptr];
            state       <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count != '0)   state_nx = ADDR;
            ADDR:    if (bus_ready_i)   state_nx = DATA;
            DATA:    if (bus_data_ok_i) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Response stage: data captured at pop, presented one cycle later.
    always_ff @(posedge clk) begin
        if (pop) begin
            rsp_lane_p1 <= mem_lane[rptr];
            rsp_data_p1 <= load_extract(bus_rdata_i, mem_addr[rptr][1:0],
                                        mem_type[rptr], mem_signed[rptr]);
        end
    end

    // Bus fields are zeroed while idle so stale queue contents never leak out.
    assign active      = (state != IDLE);
    assign bus_valid_o = (state == ADDR);
    assign bus_write_o = active && mem_write[rptr];
    assign bus_addr_o  = active ? mem_addr[rptr] : '0;
    assign bus_size_o  = active ? mem_type[rptr] : 2'd0;
    assign bus_strb_o  = (active && mem_write[rptr]) ? strobe(mem_type[rptr], mem_addr[rptr][1:0]) : 4'b0000;
    assign bus_wdata_o = active ? (mem_wdata[rptr] << {mem_addr[rptr][1:0], 3'b000}) : '0;
    assign rsp_lane_o  = rsp_valid_o ? rsp_lane_p1 : '0;
    assign rsp_data_o  = rsp_valid_o ? rsp_data_p1 : '0;
    assign busy_o      = (count != '0) || (state != IDLE) || rsp_valid_o;

endmodule

// File: tb/tb_uncached_lsu_queue.sv
// Bench for uncached_lsu_queue: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level queue model.
module tb_uncached_lsu_queue;
    localparam int LANES  = 2;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [LANES-1:0]              req_valid_i;
    logic [LANES-1:0]              req_ready_o;
    logic [LANES-1:0]              req_write_i;
    logic [LANES-1:0][1:0]         req_type_i;
    logic [LANES-1:0]              req_signed_i;
    logic [LANES-1:0][ADDR_W-1:0]  req_addr_i;
    logic [LANES-1:0][31:0]        req_wdata_i;
    logic                          err_o;
    logic                          bus_valid_o;
    logic                          bus_ready_i;
    logic                          bus_write_o;
    logic [ADDR_W-1:0]             bus_addr_o;
    logic [1:0]                    bus_size_o;
    logic [3:0]                    bus_strb_o;
    logic [31:0]                   bus_wdata_o;
    logic                          bus_data_ok_i;
    logic [31:0]                   bus_rdata_i;
    logic                          rsp_valid_o;
    logic [$clog2(LANES)-1:0]      rsp_lane_o;
    logic [31:0]                   rsp_data_o;
    logic                          busy_o;

    uncached_lsu_queue #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_type_i(req_type_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .err_o(err_o),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_write_o(bus_write_o),
        .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o), .bus_strb_o(bus_strb_o),
        .bus_wdata_o(bus_wdata_o), .bus_data_ok_i(bus_data_ok_i), .bus_rdata_i(bus_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_lane_o(rsp_lane_o), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending entries (head = the one on the bus), bus phase,
    // and what err/response must look like in the next cycle.
    typedef struct {
        bit        w;
        bit [1:0]  t;
        bit        s;
        bit [31:0] a;
        bit [31:0] d;
        int        lane;
    } ent_t;

    ent_t      q[$];
    int        phase;      // 0 waiting, 1 address phase, 2 data phase
    bit        m_err;
    bit        m_rsp;
    int        m_rsp_lane;
    bit [31:0] m_rsp_data;

    function automatic bit mis(input bit [1:0] t, input bit [31:0] a);
        return (t == 2'd1 && a[0]) || (t == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int lowest(input logic [LANES-1:0] v);
        for (int i = 0; i < LANES; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [3:0] exp_strb(input ent_t h);
        int       nb;
        bit [7:0] s;
        nb = 1 << h.t;
        s  = ((8'd1 << nb) - 8'd1) << (h.a % 4);
        return s[3:0];
    endfunction

    function automatic bit [31:0] exp_load(input ent_t h, input bit [31:0] rdata);
        int        nb;
        bit [63:0] mask, v;
        nb   = 1 << h.t;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = (64'(rdata) >> (8 * (h.a % 4))) & mask;
        if (h.s && v[8 * nb - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic check_all();
        int               l;
        logic [LANES-1:0] er;
        ent_t             h;
        l  = lowest(req_valid_i);
        er = (l >= 0 && q.size() < DEPTH) ? (LANES'(1) << l) : '0;
        check("req_ready", req_ready_o, er);
        check("err", err_o, m_err);
        check("bus_valid", bus_valid_o, phase == 1);
        check("busy", busy_o, (q.size() != 0) || (phase != 0) || m_rsp);
        check("rsp_valid", rsp_valid_o, m_rsp);
        if (m_rsp) begin
            check("rsp_lane", rsp_lane_o, m_rsp_lane);
            check("rsp_data", rsp_data_o, m_rsp_data);
        end
        if (phase != 0 && q.size() > 0) begin
            h = q[0];
            check("bus_addr", bus_addr_o, h.a);
            check("bus_write", bus_write_o, h.w);
            check("bus_size", bus_size_o, h.t);
            check("bus_strb", bus_strb_o, h.w ? exp_strb(h) : 4'b0000);
            if (h.w) check("bus_wdata", bus_wdata_o, 32'(64'(h.d) << (8 * (h.a % 4))));
        end
    endtask

    task automatic model_update();
        int   l, ph_n;
        bit   acc;
        ent_t e;
        l     = lowest(req_valid_i);
        acc   = (l >= 0) && (q.size() < DEPTH);
        ph_n  = phase;
        m_err = acc && mis(req_type_i[l], req_addr_i[l]);
        m_rsp = 1'b0;
        case (phase)
            0: if (q.size() > 0) ph_n = 1;
            1: if (bus_ready_i) ph_n = 2;
            default: if (bus_data_ok_i) begin
                ph_n = 0;
                if (!q[0].w) begin
                    m_rsp      = 1'b1;
                    m_rsp_lane = q[0].lane;
                    m_rsp_data = exp_load(q[0], bus_rdata_i);
                end
                void'(q.pop_front());
            end
        endcase
        if (acc && !mis(req_type_i[l], req_addr_i[l])) begin
            e.w = req_write_i[l]; e.t = req_type_i[l]; e.s = req_signed_i[l];
            e.a = req_addr_i[l];  e.d = req_wdata_i[l]; e.lane = l;
            q.push_back(e);
        end
        phase = ph_n;
        if (rst) begin
            q.delete();
            phase = 0;
            m_err = 1'b0;
            m_rsp = 1'b0;
        end
    endtask

    task automatic observe();
        #1;
        if (!rst) check_all();
    endtask

    task automatic advance();
        model_update();
        @(negedge clk);
    endtask

    task automatic set_req(input int lane, input bit w, input bit [1:0] t, input bit s,
                           input bit [31:0] a, input bit [31:0] d);
        req_valid_i[lane]  = 1'b1;
        req_write_i[lane]  = w;
        req_type_i[lane]   = t;
        req_signed_i[lane] = s;
        req_addr_i[lane]   = a;
        req_wdata_i[lane]  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  lane_tbl [5];
        bit  wr_tbl   [5];
        int  idx, guard;
        bit  acc, found;
        int  rsp_lanes[$];

        lane_tbl = '{0, 1, 1, 0, 1};
        wr_tbl   = '{0, 1, 0, 1, 0};
        phase = 0; m_err = 0; m_rsp = 0; m_rsp_lane = 0; m_rsp_data = '0;
        rst = 1'b1;
        req_valid_i = '0; req_write_i = '0; req_type_i = '0; req_signed_i = '0;
        req_addr_i = '0; req_wdata_i = '0;
        bus_ready_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = '0;
        @(negedge clk);
        observe(); advance();
        observe(); advance();
        rst = 1'b0;

        observe();
        check("reset_busy", busy_o, 0);
        check("reset_bus_valid", bus_valid_o, 0);
        check("reset_ready", req_ready_o, 0);
        advance();

        // Signed byte load at 0x1003.
        bus_ready_i = 1'b1; bus_data_ok_i = 1'b1; bus_rdata_i = 32'h80FFFFFF;
        set_req(0, 0, 2'd0, 1, 32'h1003, 32'h0);
        observe();
        check("t1_ready", req_ready_o, 2'b01);
        advance();
        req_valid_i = '0;
        for (int c = 1; c <= 4; c++) begin
            observe();
            if (c == 2) begin
                check("t1_addr_phase", bus_valid_o, 1);
                check("t1_strb", bus_strb_o, 4'b0000);
            end
            if (c == 3) check("t1_no_early_rsp", rsp_valid_o, 0);
            if (c == 4) begin
                check("t1_rsp_valid", rsp_valid_o, 1);
                check("t1_rsp_data", rsp_data_o, 32'hFFFFFF80);
                check("t1_rsp_lane", rsp_lane_o, 0);
            end
            advance();
        end

        // Two stores contend; lane0 wins, then lane1 half store to 0x2002.
        set_req(0, 1, 2'd2, 0, 32'h4000, 32'h11223344);
        set_req(1, 1, 2'd1, 0, 32'h2002, 32'h0000ABCD);
        observe();
        check("t2_arb", req_ready_o, 2'b01);
        advance();
        req_valid_i = 2'b10;
        observe();
        check("t2_lane1_ready", req_ready_o, 2'b10);
        advance();
        req_valid_i = '0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            observe();
            if (bus_valid_o && bus_addr_o == 32'h2002) begin
                found = 1'b1;
                check("t2_strb", bus_strb_o, 4'b1100);
                check("t2_wdata", bus_wdata_o, 32'hABCD0000);
            end
            advance();
        end
        check("t2_seen", found, 1);

        // Misaligned word load.
        set_req(0, 0, 2'd2, 0, 32'h3002, 32'h0);
        observe(); advance();
        req_valid_i = '0;
        observe();
        check("t3_err", err_o, 1);
        check("t3_busy", busy_o, 0);
        check("t3_bus_valid", bus_valid_o, 0);
        advance();
        observe();
        check("t3_err_once", err_o, 0);
        check("t3_bus_idle", bus_valid_o, 0);
        advance();

        // Fill to DEPTH with the bus stalled, then drain in order.
        bus_ready_i = 1'b0; bus_data_ok_i = 1'b0;
        idx = 0; guard = 0;
        while (idx < DEPTH && guard < 50) begin
            req_valid_i = '0;
            set_req(lane_tbl[idx], wr_tbl[idx], 2'd2, 0, 32'h5000 + 4 * idx, $urandom);
            observe();
            acc = req_ready_o[lane_tbl[idx]];
            advance();
            if (acc) idx++;
            guard++;
        end
        check("t4_accepted", idx, DEPTH);
        for (int c = 0; c < 3; c++) begin
            req_valid_i = '0;
            set_req(lane_tbl[4], wr_tbl[4], 2'd2, 0, 32'h5010, $urandom);
            observe();
            check("t4_full_ready", req_ready_o, 2'b00);
            advance();
        end
        bus_ready_i = 1'b1; bus_data_ok_i = 1'b1;
        guard = 0;
        while ((idx < DEPTH + 1 || busy_o) && guard < 80) begin
            req_valid_i = '0;
            if (idx < DEPTH + 1) set_req(lane_tbl[4], wr_tbl[4], 2'd2, 0, 32'h5010, 32'h0);
            bus_rdata_i = $urandom;
            observe();
            acc = req_ready_o[lane_tbl[4]] && (idx < DEPTH + 1);
            if (rsp_valid_o) rsp_lanes.push_back(int'(rsp_lane_o));
            advance();
            if (acc) idx++;
            guard++;
        end
        req_valid_i = '0;
        check("t4_drained", busy_o, 0);
        check("t4_rsp_count", rsp_lanes.size(), 3);
        if (rsp_lanes.size() == 3) begin
            check("t4_rsp_lane0", rsp_lanes[0], 0);
            check("t4_rsp_lane1", rsp_lanes[1], 1);
            check("t4_rsp_lane2", rsp_lanes[2], 1);
        end

        // Reset while in the data phase with two entries queued.
        bus_ready_i = 1'b1; bus_data_ok_i = 1'b0;
        set_req(0, 0, 2'd2, 0, 32'h6000, 32'h0);
        observe(); advance();
        req_valid_i = '0;
        set_req(1, 0, 2'd2, 1, 32'h6004, 32'h0);
        observe(); advance();
        req_valid_i = '0;
        observe(); advance();
        observe();
        check("t5_in_data_busy", busy_o, 1);
        check("t5_in_data_valid", bus_valid_o, 0);
        rst = 1'b1;
        advance();
        rst = 1'b0; bus_data_ok_i = 1'b1;
        observe();
        check("t5_ready", req_ready_o, 0);
        check("t5_err", err_o, 0);
        check("t5_bus_valid", bus_valid_o, 0);
        check("t5_bus_write", bus_write_o, 0);
        check("t5_bus_addr", bus_addr_o, 0);
        check("t5_bus_size", bus_size_o, 0);
        check("t5_bus_strb", bus_strb_o, 0);
        check("t5_bus_wdata", bus_wdata_o, 0);
        check("t5_rsp_valid", rsp_valid_o, 0);
        check("t5_rsp_lane", rsp_lane_o, 0);
        check("t5_rsp_data", rsp_data_o, 0);
        check("t5_busy", busy_o, 0);
        advance();
        for (int c = 0; c < 5; c++) begin
            observe(); advance();
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            req_valid_i = LANES'($urandom);
            for (int l = 0; l < LANES; l++) begin
                req_write_i[l]  = 1'($urandom);
                req_type_i[l]   = 2'($urandom_range(0, 2));
                req_signed_i[l] = 1'($urandom);
                req_addr_i[l]   = $urandom;
                req_wdata_i[l]  = $urandom;
            end
            bus_ready_i   = ($urandom_range(0, 3) != 0);
            bus_data_ok_i = ($urandom_range(0, 3) != 0);
            bus_rdata_i   = $urandom;
            rst           = ($urandom_range(0, 99) == 0);
            observe(); advance();
        end
        rst = 1'b0; req_valid_i = '0; bus_ready_i = 1'b1; bus_data_ok_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus_rdata_i = $urandom;
            observe(); advance();
        end
        check("final_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
